aes_block_fetch: RTL and testbench

- Downstream neighbour of the RAM preload stage. Once preload reports finished, this block reads the dual-port byte RAM two bytes per cycle, packs 16 bytes into a 128-bit plaintext block, and offers it to the AES core over a valid/ready handshake.
- Repeats until MEM_DEPTH bytes have been delivered, then raises a sticky done.

---
 rtl/aes_block_fetch.sv | 178 +++++++++++++++++
 tb/tb_aes_block_fetch.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_fetch.sv
// Streams MEM_DEPTH bytes from a dual-port byte RAM, two per cycle, as 128-bit blocks over valid/ready.
// Optional macro AES_BLOCK_FETCH_LAST_EN adds a block_last output flagging the final block.
module aes_block_fetch #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 64,
    localparam int unsigned IDX_W     = (ADDR_WIDTH > 4) ? ADDR_WIDTH - 4 : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] addrA,
    output logic [ADDR_WIDTH-1:0] addrB,
    output logic                  rd_enaA,
    output logic                  rd_enaB,
    input  logic [DATA_WIDTH-1:0] data_inA,
    input  logic [DATA_WIDTH-1:0] data_inB,
    output logic [127:0]          block,
    output logic                  block_valid,
    input  logic                  block_ready,
    output logic [IDX_W-1:0]      block_idx,
`ifdef AES_BLOCK_FETCH_LAST_EN
    output logic                  block_last,
`endif
    output logic                  done
);

    localparam int unsigned BLK_W = 128;
    localparam int unsigned PAIR_W = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [3:0]            issue_q, issue_d;
    logic [2:0]            cap_q, cap_d;
    logic                  cap_vld_q, cap_vld_d;

    logic [ADDR_WIDTH-1:0] addrA_d, addrB_d;
    logic                  rd_d;
    logic [BLK_W-1:0]      block_d;
    logic                  valid_d;
    logic [IDX_W-1:0]      idx_d;
    logic                  done_d;
`ifdef AES_BLOCK_FETCH_LAST_EN
    logic                  last_d;
`endif

    logic                  is_last;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [ADDR_WIDTH-1:0] next_base;

    // The final block is the one whose base sits 16 bytes below MEM_DEPTH.
    assign is_last    = ({1'b0, base_q} == (ADDR_WIDTH+1)'(MEM_DEPTH - 16));
    assign issue_addr = base_q + ADDR_WIDTH'({issue_q[2:0], 1'b0});
    assign next_base  = base_q + ADDR_WIDTH'(16);

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        issue_d   = issue_q;
        cap_d     = cap_q;
        cap_vld_d = rd_enaA;
        addrA_d   = addrA;
        addrB_d   = addrB;
        rd_d      = rd_enaA;
        block_d   = block;
        valid_d   = block_valid;
        idx_d     = block_idx;
        done_d    = done;
`ifdef AES_BLOCK_FETCH_LAST_EN
        last_d    = block_last;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    base_d  = '0;
                    addrA_d = '0;
                    addrB_d = ADDR_WIDTH'(1);
                    rd_d    = 1'b1;
                    issue_d = 4'd1;
                    cap_d   = '0;
                end
            end
            FETCH: begin
                // Issue side: eight address pairs, then strobes drop.
                if (!issue_q[3]) begin
                    addrA_d = issue_addr;
                    addrB_d = issue_addr + ADDR_WIDTH'(1);
                    rd_d    = 1'b1;
                    issue_d = issue_q + 4'd1;
                end else begin
                    rd_d    = 1'b0;
                end
                // Capture side: read data lags the strobe by one cycle.
                if (cap_vld_q) begin
                    block_d = {block[BLK_W-PAIR_W-1:0], data_inA, data_inB};
                    cap_d   = cap_q + 3'd1;
                    if (cap_q == 3'd7) begin
                        state_d = HOLD;
                        valid_d = 1'b1;
`ifdef AES_BLOCK_FETCH_LAST_EN
                        last_d  = is_last;
`endif
                    end
                end
            end
            HOLD: begin
                if (block_ready) begin
                    valid_d = 1'b0;
`ifdef AES_BLOCK_FETCH_LAST_EN
                    last_d  = 1'b0;
`endif
                    if (is_last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        // Start the next block on the transfer edge to keep a 10-clock cadence.
                        state_d = FETCH;
                        base_d  = next_base;
                        idx_d   = block_idx + IDX_W'(1);
                        addrA_d = next_base;
                        addrB_d = next_base + ADDR_WIDTH'(1);
                        rd_d    = 1'b1;
                        issue_d = 4'd1;
                        cap_d   = '0;
                    end
                end
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_q     <= '0;
            cap_q       <= '0;
            cap_vld_q   <= 1'b0;
            addrA       <= '0;
            addrB       <= '0;
            rd_enaA     <= 1'b0;
            rd_enaB     <= 1'b0;
            block       <= '0;
            block_valid <= 1'b0;
            block_idx   <= '0;
            done        <= 1'b0;
`ifdef AES_BLOCK_FETCH_LAST_EN
            block_last  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_q     <= issue_d;
            cap_q       <= cap_d;
            cap_vld_q   <= cap_vld_d;
            addrA       <= addrA_d;
            addrB       <= addrB_d;
            rd_enaA     <= rd_d;
            rd_enaB     <= rd_d;
            block       <= block_d;
            block_valid <= valid_d;
            block_idx   <= idx_d;
            done        <= done_d;
`ifdef AES_BLOCK_FETCH_LAST_EN
            block_last  <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_aes_block_fetch.sv
// Scoreboard bench for aes_block_fetch with a synchronous-read dual-port byte RAM model.
`timescale 1ns/1ps
module tb_aes_block_fetch;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 8;
`ifdef AES_BLOCK_FETCH_LAST_EN
    localparam int unsigned MD = 32;
`else
    localparam int unsigned MD = 64;
`endif
    localparam int unsigned NBLK = MD / 16;
    localparam int unsigned IW = AW - 4;
    localparam int unsigned RB = (NBLK > 2) ? 2 : 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] addrA, addrB;
    logic          rd_enaA, rd_enaB;
    logic [DW-1:0] data_inA = '0, data_inB = '0;
    logic [127:0]  block;
    logic          block_valid;
    logic          block_ready;
    logic [IW-1:0] block_idx;
    logic          done;
`ifdef AES_BLOCK_FETCH_LAST_EN
    logic          block_last;
`endif

    aes_block_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(MD)) dut (
        .clk(clk), .rst(rst), .start(start),
        .addrA(addrA), .addrB(addrB), .rd_enaA(rd_enaA), .rd_enaB(rd_enaB),
        .data_inA(data_inA), .data_inB(data_inB),
        .block(block), .block_valid(block_valid), .block_ready(block_ready),
        .block_idx(block_idx),
`ifdef AES_BLOCK_FETCH_LAST_EN
        .block_last(block_last),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:63];
    initial for (int i = 0; i < 64; i++) mem[i] = 8'(i);

    always @(posedge clk) begin
        if (rd_enaA) data_inA <= mem[addrA];
        if (rd_enaB) data_inB <= mem[addrB];
    end

    logic [127:0] exp_blk [0:3] = '{
        128'h000102030405060708090A0B0C0D0E0F,
        128'h101112131415161718191A1B1C1D1E1F,
        128'h202122232425262728292A2B2C2D2E2F,
        128'h303132333435363738393A3B3C3D3E3F
    };

    typedef struct packed {
        logic [127:0]  blk;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   xfers  = 0;
    int   last_glitch = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_blocks(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.blk  = exp_blk[i];
            e.idx  = IW'(i);
            e.last = (i == int'(NBLK) - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rd"}, 128'({addrA, addrB, rd_enaA, rd_enaB}), 128'(0));
        check({tag, "_block"}, block, 128'(0));
        check({tag, "_ctl"}, 128'({block_valid, block_idx, done}), 128'(0));
`ifdef AES_BLOCK_FETCH_LAST_EN
        check({tag, "_last"}, 128'(block_last), 128'(0));
`endif
    endtask

    task automatic wait_xfers(input string name, input int target, input int budget);
        int b;
        b = budget;
        while (xfers < target && b > 0) begin
            @(posedge clk); #2;
            b--;
        end
        check(name, 128'(xfers), 128'(target));
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; block_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (rst && block_valid && block_ready) begin
            xfers++;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_xfer", 128'(sb_q.size()), 128'(1));
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_block", block, mon_e.blk);
                check("sb_idx", 128'(block_idx), 128'(mon_e.idx));
`ifdef AES_BLOCK_FETCH_LAST_EN
                check("sb_last", 128'(block_last), 128'(mon_e.last));
`endif
            end
        end
`ifdef AES_BLOCK_FETCH_LAST_EN
        if (!block_valid && block_last) last_glitch++;
`endif
    end

    int quiet;
    int bp_bad;
    int x0;

    initial begin
        logic [14:0] act_t, exp_t_v;
        rst = 1'b0; start = 1'b0; block_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset("reset0");
        rst = 1'b1;

        // Idle with start low.
        quiet = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #2;
            if (rd_enaA || rd_enaB || block_valid) quiet++;
        end
        check("idle_quiet", 128'(quiet), 128'(0));

        // Full run from a one-cycle start pulse, cycle-exact first block.
        push_blocks(NBLK);
        x0 = xfers;
        block_ready = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (i == 0) start = 1'b0;
            act_t   = {rd_enaA, rd_enaB, block_valid, (i < 8) ? {addrA, addrB} : 12'h000};
            exp_t_v = {(i < 8), (i < 8), (i == 9),
                       (i < 8) ? {6'(2 * i), 6'(2 * i + 1)} : 12'h000};
            check($sformatf("fetch_cycle%0d", i), 128'(act_t), 128'(exp_t_v));
        end
        wait_xfers("run1_xfers", x0 + int'(NBLK), 12 * int'(NBLK) + 20);
        check("run1_done", 128'({done, block_valid}), 128'(2'b10));
        check("run1_block_kept", block, exp_blk[NBLK-1]);

        // Start pulses after done are ignored.
        quiet = 0;
        for (int p = 0; p < 3; p++) begin
            start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #2;
                if (rd_enaA || rd_enaB || block_valid || !done) quiet++;
            end
        end
        check("done_ignores_start", 128'(quiet), 128'(0));

        // Backpressure on block 1.
        do_reset();
        check_reset("reset1");
        rst = 1'b1;
        push_blocks(NBLK);
        x0 = xfers;
        block_ready = 1'b1;
        start = 1'b1;
        wait_xfers("bp_first", x0 + 1, 30);
        block_ready = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 20 && !block_valid; i++) begin
            @(posedge clk); #2;
        end
        check("bp_valid_rise", 128'(block_valid), 128'(1));
        bp_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            start = i[0];
            if (!block_valid || block !== exp_blk[1] || block_idx !== IW'(1) || rd_enaA || rd_enaB)
                bp_bad++;
        end
        check("bp_hold", 128'(bp_bad), 128'(0));
        block_ready = 1'b1;
        start = 1'b0;
        wait_xfers("bp_release", x0 + 2, 5);
        check("bp_after", 128'({rd_enaA, done, rd_enaA ? addrA : 6'd0}),
              128'({(NBLK > 2), (NBLK <= 2), (NBLK > 2) ? 6'd32 : 6'd0}));
        wait_xfers("bp_all", x0 + int'(NBLK), 12 * int'(NBLK) + 20);
        check("bp_done", 128'(done), 128'(1));

        // Asynchronous reset in the middle of a fetch, then restart.
        do_reset();
        rst = 1'b1;
        push_blocks(RB);
        x0 = xfers;
        block_ready = 1'b1;
        start = 1'b1;
        wait_xfers("ar_pre", x0 + RB, 12 * RB + 20);
        repeat (3) @(posedge clk);
        #2;
        check("ar_midfetch", 128'({rd_enaA, block_valid}), 128'(2'b10));
        rst = 1'b0;
        #0.5;
        check_reset("async_reset");
        #0.5;
        rst = 1'b1;
        check("ar_sb_drained", 128'(sb_q.size()), 128'(0));
        push_blocks(NBLK);
        x0 = xfers;
        wait_xfers("ar_restart", x0 + int'(NBLK), 12 * int'(NBLK) + 20);
        check("ar_done", 128'(done), 128'(1));

        check("sb_empty", 128'(sb_q.size()), 128'(0));
`ifdef AES_BLOCK_FETCH_LAST_EN
        check("last_only_when_valid", 128'(last_glitch), 128'(0));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
